reg_consolidator: RTL and testbench

Register-file consolidation engine: the responder on the power manager's consolidation handshake. On a begin pulse it walks the architectural map table (AMT). Each live architectural register whose physical register sits in a register-file partition about to be powered down is copied into a free physical register in a partition that stays powered, and the AMT entry is retargeted. When the walk finishes it returns a one-cycle done pulse, after which the power manager proceeds to rebuild the rename state and load the new configuration.

---
 rtl/reg_consolidator_if.sv | 39 +++
 rtl/reg_consolidator.sv | 160 ++++++++++++++++
 tb/tb_reg_consolidator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_consolidator_if.sv
// Consolidation handshake plus AMT/PRF access ports between reg_consolidator and its environment.
// The slave modport is the consolidator's view; master is the power-manager/storage side.
interface reg_consolidator_if #(
  parameter int unsigned ARCH_LOG   = 6,
  parameter int unsigned PHY_LOG    = 7,
  parameter int unsigned NUM_PARTS  = 4,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  beginConsolidation_i;
  logic [NUM_PARTS-1:0]  rfPartitionActive_i;
  logic                  consolidationDone_o;
  logic                  busy_o;
  logic                  error_o;
  logic [ARCH_LOG:0]     movedCount_o;
  logic [ARCH_LOG-1:0]   amtRdAddr_o;
  logic [PHY_LOG-1:0]    amtRdData_i;
  logic                  amtWrEn_o;
  logic [ARCH_LOG-1:0]   amtWrAddr_o;
  logic [PHY_LOG-1:0]    amtWrData_o;
  logic [PHY_LOG-1:0]    prfRdAddr_o;
  logic [DATA_WIDTH-1:0] prfRdData_i;
  logic                  prfWrEn_o;
  logic [PHY_LOG-1:0]    prfWrAddr_o;
  logic [DATA_WIDTH-1:0] prfWrData_o;

  modport slave (
    input  beginConsolidation_i, rfPartitionActive_i, amtRdData_i, prfRdData_i,
    output consolidationDone_o, busy_o, error_o, movedCount_o, amtRdAddr_o,
           amtWrEn_o, amtWrAddr_o, amtWrData_o, prfRdAddr_o, prfWrEn_o, prfWrAddr_o,
           prfWrData_o
  );

  modport master (
    output beginConsolidation_i, rfPartitionActive_i, amtRdData_i, prfRdData_i,
    input  consolidationDone_o, busy_o, error_o, movedCount_o, amtRdAddr_o,
           amtWrEn_o, amtWrAddr_o, amtWrData_o, prfRdAddr_o, prfWrEn_o, prfWrAddr_o,
           prfWrData_o
  );
endinterface

// File: rtl/reg_consolidator.sv
// Register-file consolidation engine: walks the AMT, relocating registers out of partitions
// being powered down. Optional macro CONSOLIDATE_SKIP_X0_EN keeps arch reg 0 in place.
module reg_consolidator #(
  parameter int unsigned ARCH_REGS  = 34,
  parameter int unsigned ARCH_LOG   = 6,
  parameter int unsigned PHY_REGS   = 128,
  parameter int unsigned PHY_LOG    = 7,
  parameter int unsigned NUM_PARTS  = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                clk,
  input logic                reset_n,
  reg_consolidator_if.slave  bus
);
  localparam int unsigned PART_LOG = $clog2(NUM_PARTS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] MOVE  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]           stateQ, stateD;
  logic [ARCH_LOG-1:0]  idxQ, idxD;
  logic [PHY_REGS-1:0]  usedQ, usedD;
  logic [NUM_PARTS-1:0] maskQ, maskD;
  logic [PHY_LOG-1:0]   dstQ, dstD;
  logic [ARCH_LOG:0]    movedQ, movedD;
  logic                 errorQ, errorD;

  logic [PHY_LOG-1:0]   curPhys;
  logic                 resident;
  logic                 lastIdx;
  logic                 advance;
  logic                 freeFound;
  logic [PHY_LOG-1:0]   freeIdx;
  logic [PHY_LOG-1:0]   candIdx;
  logic                 relocate;

  assign curPhys = bus.amtRdData_i;
  assign lastIdx = (idxQ == ARCH_LOG'(ARCH_REGS - 1));

`ifdef CONSOLIDATE_SKIP_X0_EN
  assign resident = maskQ[curPhys[PHY_LOG-1 -: PART_LOG]] || (idxQ == '0);
`else
  assign resident = maskQ[curPhys[PHY_LOG-1 -: PART_LOG]];
`endif

  assign relocate = (stateQ == CHECK) && !resident && freeFound;

  // Descending scan so the lowest-index free register in a live partition wins.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    candIdx   = '0;
    for (int i = PHY_REGS - 1; i >= 0; i--) begin
      candIdx = PHY_LOG'(i);
      if (!usedQ[i] && maskQ[candIdx[PHY_LOG-1 -: PART_LOG]]) begin
        freeFound = 1'b1;
        freeIdx   = candIdx;
      end
    end
  end

  always_comb begin
    stateD  = stateQ;
    idxD    = idxQ;
    usedD   = usedQ;
    maskD   = maskQ;
    dstD    = dstQ;
    movedD  = movedQ;
    errorD  = errorQ;
    advance = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.beginConsolidation_i) begin
          usedD  = '0;
          idxD   = '0;
          movedD = '0;
          errorD = 1'b0;
          maskD  = bus.rfPartitionActive_i | NUM_PARTS'(1);
          stateD = SCAN;
        end
      end
      SCAN: begin
        usedD[curPhys] = 1'b1;
        if (lastIdx) begin
          idxD   = '0;
          stateD = CHECK;
        end else begin
          idxD = idxQ + ARCH_LOG'(1);
        end
      end
      CHECK: begin
        if (resident) begin
          advance = 1'b1;
        end else if (!freeFound) begin
          errorD  = 1'b1;
          advance = 1'b1;
        end else begin
          dstD   = freeIdx;
          stateD = MOVE;
        end
      end
      MOVE: begin
        // Source stays marked used: it may still be referenced until rename is rebuilt.
        usedD[dstQ] = 1'b1;
        movedD      = movedQ + (ARCH_LOG + 1)'(1);
        advance     = 1'b1;
      end
      DONE: stateD = IDLE;
      default: stateD = IDLE;
    endcase
    if (advance) begin
      if (lastIdx) begin
        idxD   = '0;
        stateD = DONE;
      end else begin
        idxD   = idxQ + ARCH_LOG'(1);
        stateD = CHECK;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= IDLE;
      idxQ   <= '0;
      usedQ  <= '0;
      maskQ  <= '0;
      dstQ   <= '0;
      movedQ <= '0;
      errorQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      usedQ  <= usedD;
      maskQ  <= maskD;
      dstQ   <= dstD;
      movedQ <= movedD;
      errorQ <= errorD;
    end
  end

  // Write ports decode straight from state so an async reset drops them at once.
  always_comb begin
    bus.amtRdAddr_o         = idxQ;
    bus.prfRdAddr_o         = relocate ? curPhys : '0;
    bus.prfWrEn_o           = (stateQ == MOVE);
    bus.prfWrAddr_o         = (stateQ == MOVE) ? dstQ : '0;
    bus.prfWrData_o         = (stateQ == MOVE) ? bus.prfRdData_i : '0;
    bus.amtWrEn_o           = (stateQ == MOVE);
    bus.amtWrAddr_o         = (stateQ == MOVE) ? idxQ : '0;
    bus.amtWrData_o         = (stateQ == MOVE) ? dstQ : '0;
    bus.consolidationDone_o = (stateQ == DONE);
    bus.busy_o              = (stateQ != IDLE);
    bus.error_o             = errorQ;
    bus.movedCount_o        = movedQ;
  end
endmodule

// File: tb/tb_reg_consolidator.sv
// Self-checking bench for reg_consolidator: directed and randomized AMT/PRF images compared
// against a relocation model built from the consolidation rules.
module tb_reg_consolidator;
  localparam int AR = 34;
  localparam int PR = 128;

`ifdef CONSOLIDATE_SKIP_X0_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_consolidator_if #(.ARCH_LOG(6), .PHY_LOG(7), .NUM_PARTS(4), .DATA_WIDTH(64)) bus ();

  reg_consolidator #(
    .ARCH_REGS(AR), .ARCH_LOG(6), .PHY_REGS(PR), .PHY_LOG(7), .NUM_PARTS(4), .DATA_WIDTH(64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [6:0]  amt [64];
  logic [63:0] prf [PR];
  logic [6:0]  expAmt [AR];
  logic [63:0] expPrf [PR];
  int          expMoved;
  bit          expErr;
  int          nVec = 0;
  int          nErr = 0;

  assign bus.amtRdData_i = amt[bus.amtRdAddr_o];
  always @(posedge clk) bus.prfRdData_i <= prf[bus.prfRdAddr_o];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Relocation outcome from the rules: used = every mapped phys; each arch reg in a dead
  // partition takes the lowest unused phys in a live partition, else flags an error.
  task automatic modelRun(input logic [3:0] mask);
    bit         usedM [PR];
    logic [3:0] m;
    int         p, q;
    m = mask | 4'd1;
    for (int j = 0; j < PR; j++) begin
      usedM[j]  = 1'b0;
      expPrf[j] = prf[j];
    end
    for (int i = 0; i < AR; i++) begin
      expAmt[i]     = amt[i];
      usedM[amt[i]] = 1'b1;
    end
    expMoved = 0;
    expErr   = 1'b0;
    for (int i = 0; i < AR; i++) begin
      p = int'(amt[i]);
      if (m[p / 32]) continue;
      if (SKIP0 && i == 0) continue;
      q = -1;
      for (int j = 0; j < PR; j++)
        if (q < 0 && !usedM[j] && m[j / 32]) q = j;
      if (q < 0) begin
        expErr = 1'b1;
      end else begin
        expPrf[q] = prf[p];
        expAmt[i] = 7'(q);
        usedM[q]  = 1'b1;
        expMoved++;
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".done"}, bus.consolidationDone_o, 0);
    check({tag, ".busy"}, bus.busy_o, 0);
    check({tag, ".error"}, bus.error_o, 0);
    check({tag, ".moved"}, bus.movedCount_o, 0);
    check({tag, ".amtRdAddr"}, bus.amtRdAddr_o, 0);
    check({tag, ".amtWrEn"}, bus.amtWrEn_o, 0);
    check({tag, ".amtWrAddr"}, bus.amtWrAddr_o, 0);
    check({tag, ".amtWrData"}, bus.amtWrData_o, 0);
    check({tag, ".prfRdAddr"}, bus.prfRdAddr_o, 0);
    check({tag, ".prfWrEn"}, bus.prfWrEn_o, 0);
    check({tag, ".prfWrAddr"}, bus.prfWrAddr_o, 0);
    check({tag, ".prfWrData"}, bus.prfWrData_o, 0);
  endtask

  // One consolidation run; begin is driven in cycle 0, cycle n is observed at the n-th negedge.
  task automatic runOnce(input string tag, input logic [3:0] mask, input bit rePulse,
                         input bit jitter, input bit abortAtMove);
    int n, doneAt, doneCnt, wr, busyBad;
    bit expBusy;
    modelRun(mask);
    @(negedge clk);
    bus.beginConsolidation_i = 1'b1;
    bus.rfPartitionActive_i  = mask;
    n = 0; doneAt = 0; doneCnt = 0; wr = 0; busyBad = 0;
    forever begin
      @(negedge clk);
      n++;
      bus.beginConsolidation_i = rePulse && (n == 10);
      if (jitter) bus.rfPartitionActive_i = 4'($urandom);
      if (abortAtMove && bus.prfWrEn_o) begin
        reset_n = 1'b0;
        #1;
        checkIdleOutputs({tag, ".abort"});
        @(negedge clk);
        checkIdleOutputs({tag, ".abortHold"});
        reset_n = 1'b1;
        return;
      end
      if (bus.consolidationDone_o) begin
        doneCnt++;
        if (doneAt == 0) doneAt = n;
      end
      expBusy = (doneAt == 0) || (n == doneAt);
      if (bus.busy_o !== expBusy) busyBad++;
      if (bus.prfWrEn_o) begin
        prf[bus.prfWrAddr_o] = bus.prfWrData_o;
        wr++;
      end
      if (bus.amtWrEn_o) amt[bus.amtWrAddr_o] = bus.amtWrData_o;
      if (doneAt != 0 && n > doneAt) break;
      if (n >= 300) break;
    end
    check({tag, ".doneCycle"}, doneAt, 2 * AR + 1 + expMoved);
    check({tag, ".donePulses"}, doneCnt, 1);
    check({tag, ".busyWindow"}, busyBad, 0);
    check({tag, ".moved"}, bus.movedCount_o, expMoved);
    check({tag, ".error"}, bus.error_o, expErr);
    check({tag, ".prfWrites"}, wr, expMoved);
    for (int i = 0; i < AR; i++) check($sformatf("%s.amt[%0d]", tag, i), amt[i], expAmt[i]);
    for (int j = 0; j < PR; j++) check($sformatf("%s.prf[%0d]", tag, j), prf[j], expPrf[j]);
  endtask

  task automatic fillPrf();
    for (int j = 0; j < PR; j++) prf[j] = {$urandom, $urandom};
  endtask

  task automatic randomAmt();
    int pool [PR];
    int k, t;
    for (int j = 0; j < PR; j++) pool[j] = j;
    for (int j = PR - 1; j > 0; j--) begin
      k = int'($urandom_range(j, 0));
      t = pool[j]; pool[j] = pool[k]; pool[k] = t;
    end
    for (int i = 0; i < 64; i++) amt[i] = (i < AR) ? 7'(pool[i]) : 7'd0;
  endtask

  initial begin
    reset_n                  = 1'b0;
    bus.beginConsolidation_i = 1'b0;
    bus.rfPartitionActive_i  = 4'd0;
    for (int i = 0; i < 64; i++) amt[i] = 7'(i);
    fillPrf();
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset_n = 1'b1;

    // Everything already resident.
    runOnce("identity", 4'b1111, 1'b0, 1'b0, 1'b0);

    // Single relocation of arch5 out of partition 3.
    for (int i = 0; i < AR; i++) amt[i] = (i < 5) ? 7'(i) : (i == 5) ? 7'd100 : 7'(i - 1);
    prf[100] = 64'hDEAD;
    runOnce("single", 4'b0011, 1'b0, 1'b0, 1'b0);

    // Overflow: only 32 destinations for 34 evictees; re-pulse and mask jitter are ignored.
    for (int i = 0; i < AR; i++) amt[i] = 7'(32 + i);
    fillPrf();
    runOnce("overflow", 4'b0001, 1'b1, 1'b1, 1'b0);

    // Abort mid-MOVE, then a fresh run over the partially retargeted AMT.
    for (int i = 0; i < AR; i++) amt[i] = 7'(32 + i);
    runOnce("abort", 4'b0001, 1'b0, 1'b0, 1'b1);
    runOnce("afterAbort", 4'b0001, 1'b0, 1'b0, 1'b0);

`ifdef CONSOLIDATE_SKIP_X0_EN
    amt[0] = 7'd96;
    for (int i = 1; i < AR; i++) amt[i] = 7'(31 + i);
    fillPrf();
    runOnce("skipX0", 4'b0001, 1'b0, 1'b0, 1'b0);
`endif

    for (int r = 0; r < 8; r++) begin
      randomAmt();
      fillPrf();
      runOnce($sformatf("rand%0d", r), 4'($urandom), r[0], r[1], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
